uart_tx_module: RTL

8N1 UART transmitter that drains the ICAP controller's byte FIFO toward the host serial link. It accepts a one-cycle byte strobe from the FIFO output, serialises the byte LSB-first at a parameterised baud rate, and drives the `uart_busy` back-pressure the FIFO samples before each pop. It sits directly downstream of the FIFO, and its `tx` pin is the board UART TX line.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_module.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX path (and the RX path that will follow).
// Contents: the frame FSM state encoding, the frame format constants and the
// default bit period for 100 MHz / 115200 baud.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int UART_DATA_BITS          = 8;
   localparam int UART_STOP_BITS          = 1;
   localparam int UART_CLKS_PER_BIT_DEF   = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator shared by the UART TX and RX paths.
// Counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick for one cycle on
// the last count of each bit period, then wraps to 0.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   clear    - synchronous counter clear (wins over enable)
//   enable   - count while high
//   bit_tick - one-cycle end-of-bit-period strobe
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == CNT_LAST) cnt <= '0;
         else                 cnt <= cnt + CNT_W'(1);
      end
   end

   assign bit_tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter draining the ICAP byte FIFO toward the host link.
// A one-cycle data_valid strobe in IDLE latches data_in; the byte is sent
// LSB-first at CLKS_PER_BIT clocks per bit. Strobes arriving mid-frame are
// dropped and set the sticky overrun flag.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   data_in    - byte to send, sampled only in IDLE with data_valid
//   data_valid - one-cycle byte strobe from the FIFO
//   tx         - serial line, idles high
//   uart_busy  - back-pressure to the FIFO
//   overrun    - sticky: strobe seen while a frame was in flight
//
// state  | meaning
// IDLE   | line high, waiting for a strobe
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (high)
module uart_tx_module
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       tx,
   output logic       uart_busy,
   output logic       overrun
);

   localparam logic [2:0] BIT_IDX_LAST = 3'(UART_DATA_BITS - 1);

   uart_state_e               state;
   uart_state_e               state_nxt;
   logic [UART_DATA_BITS-1:0] shreg;
   logic [2:0]                bit_idx;
   logic                      bit_tick;
   logic                      accept;
`ifdef UART_TX_PARITY_EN
   logic                      parity_bit;
`endif

   assign accept = (state == IDLE) && data_valid;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (accept),
      .enable   (state != IDLE),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (data_valid) state_nxt = START;
         START:  if (bit_tick)   state_nxt = DATA;
         DATA: begin
            // bit index wrapping 7 -> 0 ends the data field
            if (bit_tick && (bit_idx == BIT_IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_tick)   state_nxt = STOP;
`endif
         STOP:   if (bit_tick)   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         START:  tx = 1'b0;
         DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx = parity_bit;
`endif
         default: tx = 1'b1;
      endcase
   end

   // combinational on data_valid so the FIFO cannot pop twice back-to-back
   assign uart_busy = (state != IDLE) || data_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg   <= '0;
         bit_idx <= '0;
         overrun <= 1'b0;
      end else begin
         if (accept) begin
            shreg   <= data_in;
            bit_idx <= '0;
         end else if ((state == DATA) && bit_tick) begin
            shreg   <= {1'b0, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (data_valid && (state != IDLE)) overrun <= 1'b1;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    parity_bit <= 1'b0;
      else if (accept) parity_bit <= ^data_in;
   end
`endif

endmodule
